// File: rtl/bus_cycle_controller.sv
// Bus cycle sequencer: decodes each CPU request onto ROM/SRAM/DRAM selects, counts
// per-region wait states, acknowledges or errors, and interleaves DRAM refresh.
module bus_cycle_controller #(
  parameter int ROM_WAIT       = 3,
  parameter int SRAM_WAIT      = 1,
  parameter int DRAM_WAIT      = 4,
  parameter int REFRESH_PERIOD = 390,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ack,
  output logic        berr,
  output logic        CS_rom,
  output logic        CS_sram,
  output logic        CS_dram,
  output logic        refresh,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    ACK,
    RECOVER,
    BERR,
    REFRESH
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] ref_cnt;
  logic        refresh_pending;
  logic        hit_rom;
  logic        hit_sram;
  logic        hit_dram;
  logic        wrap;

  assign hit_rom  = (addr >= 32'hFFF0_0000) && (addr <= 32'hFFF7_FFFF);
  assign hit_sram = (addr <= 32'h000F_FFFF);
  assign hit_dram = (addr >= 32'hC000_0000) && (addr <= 32'hC007_FFFF);
  assign wrap     = (ref_cnt == 16'(REFRESH_PERIOD - 1));

  // A wrap seen in IDLE is taken at once, so refresh beats a request on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      wait_cnt        <= 8'd0;
      ref_cnt         <= 16'd0;
      refresh_pending <= 1'b0;
      ack             <= 1'b0;
      berr            <= 1'b0;
      CS_rom          <= 1'b0;
      CS_sram         <= 1'b0;
      CS_dram         <= 1'b0;
      refresh         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ref_cnt <= wrap ? 16'd0 : ref_cnt + 16'd1;
      if (wrap)
        refresh_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (refresh_pending || wrap) begin
            state           <= REFRESH;
            refresh_pending <= 1'b0;
            refresh         <= 1'b1;
            busy            <= 1'b1;
            wait_cnt        <= 8'(REFRESH_CYCLES - 1);
          end else if (req) begin
            busy <= 1'b1;
            if (hit_rom) begin
              state    <= ACCESS;
              CS_rom   <= 1'b1;
              wait_cnt <= 8'(ROM_WAIT);
            end else if (hit_sram) begin
              state    <= ACCESS;
              CS_sram  <= 1'b1;
              wait_cnt <= 8'(SRAM_WAIT);
            end else if (hit_dram) begin
              state    <= ACCESS;
              CS_dram  <= 1'b1;
              wait_cnt <= 8'(DRAM_WAIT);
            end else begin
              state <= BERR;
              berr  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt == 8'd0) begin
            state <= ACK;
            ack   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ACK: begin
          state   <= RECOVER;
          ack     <= 1'b0;
          CS_rom  <= 1'b0;
          CS_sram <= 1'b0;
          CS_dram <= 1'b0;
        end
        RECOVER: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        BERR: begin
          if (!req) begin
            state <= IDLE;
            berr  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        REFRESH: begin
          if (wait_cnt == 8'd0) begin
            state   <= IDLE;
            refresh <= 1'b0;
            busy    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ack     <= 1'b0;
          berr    <= 1'b0;
          CS_rom  <= 1'b0;
          CS_sram <= 1'b0;
          CS_dram <= 1'b0;
          refresh <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller: per-cycle vector table plus
// hand-written refresh-collision and reset-mid-access sequences.
module tb_bus_cycle_controller;
  localparam int P = 390;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_ACK  = 7'b1000000;
  localparam logic [6:0] O_BERR = 7'b0100000;
  localparam logic [6:0] O_ROM  = 7'b0010000;
  localparam logic [6:0] O_SRAM = 7'b0001000;
  localparam logic [6:0] O_DRAM = 7'b0000100;
  localparam logic [6:0] O_REF  = 7'b0000010;
  localparam logic [6:0] O_BUSY = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        ack, berr, CS_rom, CS_sram, CS_dram, refresh, busy;
  logic [6:0]  obs;

  assign obs = {ack, berr, CS_rom, CS_sram, CS_dram, refresh, busy};

  bus_cycle_controller #(
    .ROM_WAIT      (3),
    .SRAM_WAIT     (1),
    .DRAM_WAIT     (4),
    .REFRESH_PERIOD(P),
    .REFRESH_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .ack    (ack),
    .berr   (berr),
    .CS_rom (CS_rom),
    .CS_sram(CS_sram),
    .CS_dram(CS_dram),
    .refresh(refresh),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rq;
    logic [31:0] a;
    logic [6:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic rst_n, input logic rq, input logic [31:0] a,
                     input logic [6:0] exp);
    vec_t v;
    v.rst_n = rst_n;
    v.rq    = rq;
    v.a     = a;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {ack,berr,rom,sram,dram,ref,busy}=%b expected %b", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    reset = 1'b0;
    req   = 1'b0;
    addr  = 32'h0;

    // reset with a request pending, then release
    add(0, 1, 32'hFFF0_0000, O_NONE);
    add(0, 1, 32'hFFF0_0000, O_NONE);
    add(1, 0, 32'hFFF0_0000, O_NONE);
    // ROM read: 5 cycles of CS, ack in the 5th, held req does not restart
    add(1, 1, 32'hFFF0_0010, O_ROM | O_BUSY);
    for (int i = 0; i < 3; i++) add(1, 1, 32'hFFF0_0010, O_ROM | O_BUSY);
    add(1, 1, 32'hFFF0_0010, O_ACK | O_ROM | O_BUSY);
    for (int i = 0; i < 3; i++) add(1, 1, 32'hFFF0_0010, O_BUSY);
    add(1, 0, 32'hFFF0_0010, O_NONE);
    add(1, 0, 32'hFFF0_0010, O_NONE);
    // unmapped: berr held 10 clocks, clears after req falls
    for (int i = 0; i < 10; i++) add(1, 1, 32'h8000_0000, O_BERR | O_BUSY);
    add(1, 0, 32'h8000_0000, O_NONE);
    // SRAM top word
    add(1, 1, 32'h000F_FFFC, O_SRAM | O_BUSY);
    add(1, 1, 32'h000F_FFFC, O_SRAM | O_BUSY);
    add(1, 1, 32'h000F_FFFC, O_ACK | O_SRAM | O_BUSY);
    add(1, 1, 32'h000F_FFFC, O_BUSY);
    add(1, 0, 32'h000F_FFFC, O_NONE);
    // DRAM top word
    for (int i = 0; i < 5; i++) add(1, 1, 32'hC007_FFFC, O_DRAM | O_BUSY);
    add(1, 1, 32'hC007_FFFC, O_ACK | O_DRAM | O_BUSY);
    add(1, 1, 32'hC007_FFFC, O_BUSY);
    add(1, 0, 32'hC007_FFFC, O_NONE);
    // ROM top word
    for (int i = 0; i < 4; i++) add(1, 1, 32'hFFF7_FFFC, O_ROM | O_BUSY);
    add(1, 1, 32'hFFF7_FFFC, O_ACK | O_ROM | O_BUSY);
    add(1, 1, 32'hFFF7_FFFC, O_BUSY);
    add(1, 0, 32'hFFF7_FFFC, O_NONE);
    // first address past ROM is unmapped
    add(1, 1, 32'hFFF8_0000, O_BERR | O_BUSY);
    add(1, 0, 32'hFFF8_0000, O_NONE);

    foreach (vecs[i]) begin
      reset = vecs[i].rst_n;
      req   = vecs[i].rq;
      addr  = vecs[i].a;
      step();
      check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // reset in the 2nd ACCESS cycle of a DRAM read
    reset = 1'b0; req = 1'b0; step();
    check("mid_pre_reset", obs, O_NONE);
    reset = 1'b1; req = 1'b1; addr = 32'hC000_0000; step();
    check("mid_acc1", obs, O_DRAM | O_BUSY);
    step();
    check("mid_acc2", obs, O_DRAM | O_BUSY);
    reset = 1'b0; step();
    check("mid_abort", obs, O_NONE);
    reset = 1'b1; req = 1'b0;
    bad = 0;
    for (int k = 1; k < P; k++) begin
      step();
      if (obs !== O_NONE) bad++;
    end
    check_int("mid_quiet_cycles", bad, 0);
    step();
    check("mid_refresh_at_period", obs, O_REF | O_BUSY);
    for (int j = 1; j < 4; j++) begin
      step();
      check($sformatf("mid_refresh%0d", j), obs, O_REF | O_BUSY);
    end
    step();
    check("mid_refresh_end", obs, O_NONE);

    // DRAM request on the same edge the refresh counter wraps
    reset = 1'b0; step();
    reset = 1'b1; req = 1'b0;
    for (int k = 1; k < P; k++) step();
    check("coll_pre", obs, O_NONE);
    req = 1'b1; addr = 32'hC000_0100; step();
    check("coll_ref0", obs, O_REF | O_BUSY);
    for (int j = 1; j < 4; j++) begin
      step();
      check($sformatf("coll_ref%0d", j), obs, O_REF | O_BUSY);
    end
    step();
    check("coll_gap", obs, O_NONE);
    step();
    check("coll_acc0", obs, O_DRAM | O_BUSY);
    for (int j = 1; j < 5; j++) begin
      step();
      check($sformatf("coll_acc%0d", j), obs, O_DRAM | O_BUSY);
    end
    step();
    check("coll_ack", obs, O_ACK | O_DRAM | O_BUSY);
    step();
    check("coll_recover", obs, O_BUSY);
    req = 1'b0; step();
    check("coll_idle", obs, O_NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_cycle_controller.md
# bus_cycle_controller

Sequences every processor bus cycle onto the ROM, SRAM and DRAM chip selects, inserting per-region wait states and returning a one-cycle acknowledge or a bus error. It also owns the DRAM refresh timer and arbitrates refresh against processor accesses. It sits between the CPU bus interface and the memory chip-select pins, in place of a purely static decode.

## Interface
Parameters:
- ROM_WAIT, 3: wait states for ROM accesses (0..255).
- SRAM_WAIT, 1: wait states for SRAM accesses (0..255).
- DRAM_WAIT, 4: wait states for DRAM accesses (0..255).
- REFRESH_PERIOD, 390: clocks between refresh requests (2..65535).
- REFRESH_CYCLES, 4: clocks `refresh` is held per refresh (1..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  CPU cycle request; held high until the cycle ends.
- addr  in  32  CPU address; sampled when a request is accepted.
- ack  out  1  one-cycle transfer acknowledge.
- berr  out  1  bus error; held until `req` falls.
- CS_rom  out  1  ROM chip select, active-high.
- CS_sram  out  1  SRAM chip select, active-high.
- CS_dram  out  1  DRAM chip select, active-high.
- refresh  out  1  DRAM refresh strobe, active-high.
- busy  out  1  high in every state except IDLE.

## Operation
- Memory map, decoded on the accepted address:
  - ROM: 0xFFF00000–0xFFF7FFFF.
  - SRAM: 0x00000000–0x000FFFFF.
  - DRAM: 0xC0000000–0xC007FFFF.
  - Any other address is unmapped.
- All outputs are registered, with no combinational path from inputs to outputs.
- State machine: IDLE, ACCESS, ACK, RECOVER, BERR, REFRESH.
- IDLE:
  - If `refresh_pending`, go to REFRESH. Refresh wins over `req` in the same cycle.
  - Otherwise, if `req` is high, latch the region and load the wait counter with that region's WAIT value.
  - A mapped address goes to ACCESS; an unmapped address goes to BERR.
- ACCESS:
  - The selected CS is high.
  - The counter decrements each cycle; when it reads 0, go to ACK.
  - ACCESS therefore lasts WAIT+1 cycles.
- ACK: `ack`=1 for exactly one cycle, CS still high, then go to RECOVER.
- RECOVER: all CS low. Stay until `req`=0, then go to IDLE. This stops a held `req` from starting a second cycle.
- BERR: `berr`=1 and no CS is asserted. When `req`=0, go to IDLE with `berr` cleared.
- REFRESH:
  - `refresh`=1 for REFRESH_CYCLES cycles with all CS low.
  - `refresh_pending` clears on entry.
  - Then go to IDLE. A `req` that waited is accepted at that point.
- Refresh timer:
  - A 16-bit free-running counter runs 0..REFRESH_PERIOD-1 and wraps.
  - On the wrap it sets `refresh_pending`.
  - A wrap while a refresh is already pending does not accumulate; one refresh is owed.
- At most one CS is ever high. CS and `refresh` are never high together.
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE.
  - All outputs go to 0: `ack`, `berr`, CS_*, `refresh`, `busy`.
  - The wait counter, refresh counter and `refresh_pending` clear.
  - Reset mid-access or mid-refresh aborts immediately.

## Timing
- Take edge 0 as the edge where IDLE samples `req`=1 with no refresh pending.
- CS rises after edge 0 and stays high through ACCESS and ACK.
- `ack` is high in the cycle after edge WAIT+1 and falls after edge WAIT+2. Acknowledge latency is therefore WAIT+2 clocks.
- CS falls after edge WAIT+2.
- `berr` rises after edge 0. It falls after the first edge that samples `req`=0.
- Minimum spacing between request acceptances is WAIT+4 clocks: ACCESS, ACK, one RECOVER cycle with `req`=0, then IDLE.
- After reset release, the first `refresh_pending` sets at the edge where the refresh counter wraps, REFRESH_PERIOD edges later.

## Test plan
- Reset: hold `reset`=0 for 2 clocks with `req`=1 and addr=0xFFF00000. Every output must stay 0 throughout, and `busy`=0 after release.
- ROM read: addr 0xFFF00010, ROM_WAIT=3. Required response:
  - CS_rom high for 5 cycles.
  - `ack` high in exactly the 5th cycle.
  - No second cycle while `req` stays high; a new access only after `req` is low for at least 1 clock.
- Unmapped access: addr 0x80000000. `berr` rises 1 clock later with every CS 0 and is held for 10 clocks while `req` stays high. `berr` clears the clock after `req` falls.
- Refresh collision: `req` to DRAM 0xC0000100 arrives in the same cycle the refresh counter wraps. Required response:
  - `refresh` is high for 4 clocks first.
  - CS_dram then asserts, and `ack` follows 6 clocks after DRAM acceptance.
- Reset mid-access: assert `reset`=0 in the 2nd ACCESS cycle of a DRAM read. At the next edge all outputs must be 0 and no `ack` may ever appear. A refresh must fire REFRESH_PERIOD edges after release.
- Region sweep: SRAM 0x000FFFFC, DRAM 0xC007FFFC, ROM 0xFFF7FFFC and ROM boundary 0xFFF80000. The first three return `ack` after 3, 6 and 5 clocks; 0xFFF80000 returns `berr`.
